inst_fetch: RTL and testbench
=============================

// Module: inst_fetch
// PURPOSE
//  Fetch stage directly upstream of the instruction ROM: owns the program counter, drives InstAddress,
//  captures the combinational ROM word into an instruction register for decode, and handles start,
//  stall, branch redirect/flush and halt. Also reports program completion and the run-cycle count.
// PARAMETERS
//  A   10          PC / ROM address width (ROM depth 2**A)
//  W   9           instruction width
//  OW  6           signed relative-branch offset width
//  CW  16          CycleCount width
// PORTS
//  Clk           in   1    system clock, all state on rising edge
//  Reset_n       in   1    asynchronous, active-low reset
//  Start         in   1    1-cycle pulse: (re)start program at StartAddr
//  StartAddr     in   A    initial PC
//  Stall         in   1    downstream hold; freezes whole stage
//  BranchEn      in   1    redirect request from execute, qualified by InstValid
//  BranchRel     in   1    1: target = InstPC + sext(BranchOff); 0: target = BranchTarget
//  BranchOff     in   OW   signed offset (two's complement)
//  BranchTarget  in   A    absolute target
//  InstAddress   out  A    = PC, drives ROM address (combinational ROM, same-cycle data)
//  InstIn        in   W    ROM data
//  InstOut       out  W    registered instruction for decode
//  InstPC        out  A    address of InstOut
//  InstValid     out  1    InstOut holds an issued instruction
//  Halted        out  1    state == HALT
//  Done          out  1    1-cycle pulse on entering HALT
//  CycleCount    out  CW   cycles spent in RUN since last Start, saturating
// BEHAVIOUR
//  Reset (async, Reset_n=0): state IDLE; PC=0, InstOut=0, InstPC=0, InstValid=0, Done=0, CycleCount=0;
//   Halted=0. Reset mid-run discards in-flight instruction; no Done.
//  States IDLE -> RUN on Start; RUN -> HALT on halt fetch; HALT -> RUN on Start; Start in RUN restarts.
//  Start (any state, highest priority after reset): PC<=StartAddr, InstValid<=0, CycleCount<=0, state RUN.
//  RUN, priority Start > Stall > BranchEn&InstValid > halt > normal:
//   Stall=1: PC, InstOut, InstPC, InstValid held; BranchEn ignored (execute holds it); CycleCount++.
//   Branch: PC<=target; InstValid<=0 (word fetched this cycle squashed); 1 bubble per taken branch.
//   Relative target arithmetic modulo 2**A (sext BranchOff to A bits, wrap, no error).
//   Halt: InstIn == HALT_WORD ('1): not issued, InstValid<=0, PC held at halt address, Done<=1, state HALT.
//   Normal: InstOut<=InstIn, InstPC<=PC, InstValid<=1, PC<=PC+1 (2**A-1 wraps to 0).
//  Latency: ROM word at PC visible on InstOut 1 cycle after PC presented; throughput 1/cycle unstalled.
//  IDLE/HALT: PC, InstOut, InstPC held; InstValid=0; BranchEn/Stall ignored; CycleCount held.
//  CycleCount increments every RUN cycle (incl. stall, halt-detect cycle), saturates at 2**CW-1.
//  Done is registered, high exactly one cycle; Halted high from that same cycle until Start/reset.
// STRUCTURE
//  Package fetch_pkg: typedef enum logic[1:0] {IDLE, RUN, HALT} fetch_state_t; HALT_WORD localparam;
//   default A/W/OW widths shared with the ROM and decode stages.
//  One sub-module: pc_next (combinational) computing next PC from state, Start, Stall, branch, halt;
//   inst_fetch holds the state/PC/IR/counter registers.
// TESTING
//  1 ROM 0:addi,1:addi,2:halt; Start, StartAddr=0 -> InstOut addi@PC0,1 valid cycles 2-3; Done pulse; PC=2.
//  2 Branch absolute: InstValid at PC3, BranchEn, BranchTarget=10 -> next valid InstPC=10, one bubble.
//  3 Relative: InstPC=5, BranchOff=-3 -> InstPC 2; InstPC=1, BranchOff=-4 -> wraps to 1021.
//  4 Stall 3 cycles mid-stream -> InstOut/InstPC/InstValid unchanged, CycleCount +3, no skipped address.
//  5 StartAddr=1023, no halt -> InstPC sequence 1023, 0, 1; Start during RUN -> flush, restart at StartAddr.
//  6 Reset_n low asynchronously between edges mid-run -> all outputs 0 immediately, Done never pulses.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared fetch-stage types and widths, also used by the ROM and decode stages.
// Holds the state/action encodings and the reserved halt opcode.
package fetch_pkg;

    localparam int A_DEF  = 10;
    localparam int W_DEF  = 9;
    localparam int OW_DEF = 6;
    localparam int CW_DEF = 16;

    localparam logic [W_DEF-1:0] HALT_WORD = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_t;

    // Single decision per cycle; the register file in inst_fetch acts on it.
    typedef enum logic [2:0] {
        ACT_HOLD   = 3'd0,
        ACT_START  = 3'd1,
        ACT_BRANCH = 3'd2,
        ACT_HALT   = 3'd3,
        ACT_ISSUE  = 3'd4
    } fetch_act_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-stage bus: control/redirect inputs, ROM address/data and issued instruction to decode.
// master = fetch stage, slave = surrounding core (execute, ROM, decode).
interface inst_fetch_if #(
    parameter int A  = fetch_pkg::A_DEF,
    parameter int W  = fetch_pkg::W_DEF,
    parameter int OW = fetch_pkg::OW_DEF,
    parameter int CW = fetch_pkg::CW_DEF
) ();

    logic          Start;
    logic [A-1:0]  StartAddr;
    logic          Stall;
    logic          BranchEn;
    logic          BranchRel;
    logic [OW-1:0] BranchOff;
    logic [A-1:0]  BranchTarget;
    logic [A-1:0]  InstAddress;
    logic [W-1:0]  InstIn;
    logic [W-1:0]  InstOut;
    logic [A-1:0]  InstPC;
    logic          InstValid;
    logic          Halted;
    logic          Done;
    logic [CW-1:0] CycleCount;

    modport master (
        input  Start, StartAddr, Stall, BranchEn, BranchRel, BranchOff, BranchTarget, InstIn,
        output InstAddress, InstOut, InstPC, InstValid, Halted, Done, CycleCount
    );

    modport slave (
        output Start, StartAddr, Stall, BranchEn, BranchRel, BranchOff, BranchTarget, InstIn,
        input  InstAddress, InstOut, InstPC, InstValid, Halted, Done, CycleCount
    );

endinterface

// File: rtl/inst_fetch_pc_next.sv
// Combinational next-PC and per-cycle action select; priority Start > Stall > branch > halt > issue.
// Zero latency; Stall simply yields ACT_HOLD with the PC unchanged.
module pc_next
    import fetch_pkg::*;
#(
    parameter int A  = A_DEF,
    parameter int OW = OW_DEF
) (
    input  fetch_state_t  state_i,
    input  logic          start_i,
    input  logic [A-1:0]  start_addr_i,
    input  logic          stall_i,
    input  logic          branch_en_i,
    input  logic          inst_valid_i,
    input  logic          branch_rel_i,
    input  logic [OW-1:0] branch_off_i,
    input  logic [A-1:0]  branch_target_i,
    input  logic [A-1:0]  inst_pc_i,
    input  logic [A-1:0]  pc_i,
    input  logic          halt_word_i,
    output fetch_act_t    act_o,
    output logic [A-1:0]  pc_d_o
);

    logic [A-1:0] rel_target;

    // Offset is relative to the instruction being executed, not the current fetch PC.
    assign rel_target = inst_pc_i + {{(A-OW){branch_off_i[OW-1]}}, branch_off_i};

    always_comb begin
        act_o  = ACT_HOLD;
        pc_d_o = pc_i;
        if (start_i) begin
            act_o  = ACT_START;
            pc_d_o = start_addr_i;
        end else if (state_i == RUN) begin
            if (stall_i) begin
                act_o = ACT_HOLD;
            end else if (branch_en_i && inst_valid_i) begin
                act_o  = ACT_BRANCH;
                pc_d_o = branch_rel_i ? rel_target : branch_target_i;
            end else if (halt_word_i) begin
                act_o = ACT_HALT;
            end else begin
                act_o  = ACT_ISSUE;
                pc_d_o = pc_i + A'(1);
            end
        end
    end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC, instruction register, IDLE/RUN/HALT control and saturating run-cycle counter.
// ROM word at PC appears on InstOut one cycle later; Stall freezes the whole stage.
module inst_fetch
    import fetch_pkg::*;
#(
    parameter int A  = A_DEF,
    parameter int W  = W_DEF,
    parameter int OW = OW_DEF,
    parameter int CW = CW_DEF
) (
    input  logic        Clk,
    input  logic        Reset_n,
    inst_fetch_if.master bus
);

    fetch_state_t  state_q, state_d;
    fetch_act_t    act;
    logic [A-1:0]  pc_q, pc_d;
    logic [W-1:0]  inst_q, inst_d;
    logic [A-1:0]  ipc_q, ipc_d;
    logic          vld_q, vld_d;
    logic          done_q, done_d;
    logic [CW-1:0] cnt_q, cnt_d;

    pc_next #(.A(A), .OW(OW)) u_pc_next (
        .state_i         (state_q),
        .start_i         (bus.Start),
        .start_addr_i    (bus.StartAddr),
        .stall_i         (bus.Stall),
        .branch_en_i     (bus.BranchEn),
        .inst_valid_i    (vld_q),
        .branch_rel_i    (bus.BranchRel),
        .branch_off_i    (bus.BranchOff),
        .branch_target_i (bus.BranchTarget),
        .inst_pc_i       (ipc_q),
        .pc_i            (pc_q),
        .halt_word_i     (&bus.InstIn),
        .act_o           (act),
        .pc_d_o          (pc_d)
    );

    always_comb begin
        state_d = state_q;
        inst_d  = inst_q;
        ipc_d   = ipc_q;
        vld_d   = vld_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        if (state_q == RUN && cnt_q != '1) begin
            cnt_d = cnt_q + CW'(1);
        end
        case (act)
            ACT_START: begin
                state_d = RUN;
                vld_d   = 1'b0;
                cnt_d   = '0;
            end
            ACT_BRANCH: vld_d = 1'b0;
            ACT_HALT: begin
                state_d = HALT;
                vld_d   = 1'b0;
                done_d  = 1'b1;
            end
            ACT_ISSUE: begin
                inst_d = bus.InstIn;
                ipc_d  = pc_q;
                vld_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            inst_q  <= '0;
            ipc_q   <= '0;
            vld_q   <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ipc_q   <= ipc_d;
            vld_q   <= vld_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.InstAddress = pc_q;
    assign bus.InstOut     = inst_q;
    assign bus.InstPC      = ipc_q;
    assign bus.InstValid   = vld_q;
    assign bus.Halted      = (state_q == HALT);
    assign bus.Done        = done_q;
    assign bus.CycleCount  = cnt_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a behavioural combinational ROM.
module tb_inst_fetch;
    import fetch_pkg::*;

    logic Clk;
    logic Reset_n;
    int   checks;
    int   failures;
    logic [8:0] rom [1024];

    inst_fetch_if bus ();

    inst_fetch dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    assign bus.InstIn = rom[bus.InstAddress];

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_start(input logic [9:0] addr);
        bus.Start = 1'b1;
        bus.StartAddr = addr;
        tick();
        bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (bus.InstAddress !== 10'd0) begin failures++; $display("FAIL rst_pc got=%0d exp=0", bus.InstAddress); end
        checks++; if (bus.InstValid !== 1'b0 || bus.Done !== 1'b0 || bus.Halted !== 1'b0) begin failures++; $display("FAIL rst_flags got=%b%b%b exp=000", bus.InstValid, bus.Done, bus.Halted); end
        checks++; if (bus.InstOut !== 9'd0 || bus.InstPC !== 10'd0 || bus.CycleCount !== 16'd0) begin failures++; $display("FAIL rst_regs got=%0d/%0d/%0d exp=0/0/0", bus.InstOut, bus.InstPC, bus.CycleCount); end
        Reset_n = 1'b1;
        // IDLE ignores branch and stall
        bus.BranchEn = 1'b1; bus.BranchTarget = 10'd77;
        tick(); tick();
        bus.BranchEn = 1'b0;
        checks++; if (bus.InstAddress !== 10'd0 || bus.InstValid !== 1'b0 || bus.CycleCount !== 16'd0) begin failures++; $display("FAIL idle_hold got=%0d/%b/%0d exp=0/0/0", bus.InstAddress, bus.InstValid, bus.CycleCount); end
    endtask

    task automatic test_program_halt();
        do_start(10'd0);
        checks++; if (bus.InstAddress !== 10'd0 || bus.InstValid !== 1'b0 || bus.CycleCount !== 16'd0) begin failures++; $display("FAIL p_start got=%0d/%b/%0d exp=0/0/0", bus.InstAddress, bus.InstValid, bus.CycleCount); end
        tick();
        checks++; if (bus.InstOut !== 9'h0A1 || bus.InstPC !== 10'd0 || bus.InstValid !== 1'b1 || bus.CycleCount !== 16'd1) begin failures++; $display("FAIL p_i0 got=%h/%0d/%b/%0d exp=0a1/0/1/1", bus.InstOut, bus.InstPC, bus.InstValid, bus.CycleCount); end
        tick();
        checks++; if (bus.InstOut !== 9'h0A2 || bus.InstPC !== 10'd1 || bus.InstValid !== 1'b1 || bus.InstAddress !== 10'd2) begin failures++; $display("FAIL p_i1 got=%h/%0d/%b/%0d exp=0a2/1/1/2", bus.InstOut, bus.InstPC, bus.InstValid, bus.InstAddress); end
        tick();
        checks++; if (bus.InstValid !== 1'b0 || bus.Done !== 1'b1 || bus.Halted !== 1'b1 || bus.InstAddress !== 10'd2 || bus.CycleCount !== 16'd3) begin failures++; $display("FAIL p_halt got=%b%b%b/%0d/%0d exp=011/2/3", bus.InstValid, bus.Done, bus.Halted, bus.InstAddress, bus.CycleCount); end
        tick();
        checks++; if (bus.Done !== 1'b0 || bus.Halted !== 1'b1 || bus.InstAddress !== 10'd2 || bus.CycleCount !== 16'd3 || bus.InstOut !== 9'h0A2) begin failures++; $display("FAIL p_after got=%b%b/%0d/%0d/%h exp=01/2/3/0a2", bus.Done, bus.Halted, bus.InstAddress, bus.CycleCount, bus.InstOut); end
        rom[2] = 9'h002;
    endtask

    task automatic test_branch_abs();
        do_start(10'd3);
        checks++; if (bus.Halted !== 1'b0 || bus.InstValid !== 1'b0 || bus.InstAddress !== 10'd3) begin failures++; $display("FAIL ba_restart got=%b/%b/%0d exp=0/0/3", bus.Halted, bus.InstValid, bus.InstAddress); end
        tick();
        bus.BranchEn = 1'b1; bus.BranchRel = 1'b0; bus.BranchTarget = 10'd10;
        tick();
        bus.BranchEn = 1'b0;
        checks++; if (bus.InstValid !== 1'b0 || bus.InstAddress !== 10'd10) begin failures++; $display("FAIL ba_bubble got=%b/%0d exp=0/10", bus.InstValid, bus.InstAddress); end
        tick();
        checks++; if (bus.InstPC !== 10'd10 || bus.InstOut !== 9'h00A || bus.InstValid !== 1'b1) begin failures++; $display("FAIL ba_target got=%0d/%h/%b exp=10/00a/1", bus.InstPC, bus.InstOut, bus.InstValid); end
    endtask

    task automatic test_branch_rel();
        do_start(10'd5);
        tick();
        bus.BranchEn = 1'b1; bus.BranchRel = 1'b1; bus.BranchOff = 6'h3D;
        tick();
        bus.BranchEn = 1'b0;
        tick();
        checks++; if (bus.InstPC !== 10'd2 || bus.InstValid !== 1'b1) begin failures++; $display("FAIL br_back got=%0d/%b exp=2/1", bus.InstPC, bus.InstValid); end
        do_start(10'd1);
        tick();
        bus.BranchEn = 1'b1; bus.BranchOff = 6'h3C;
        tick();
        bus.BranchEn = 1'b0;
        checks++; if (bus.InstAddress !== 10'd1021 || bus.InstValid !== 1'b0) begin failures++; $display("FAIL br_wrap_pc got=%0d/%b exp=1021/0", bus.InstAddress, bus.InstValid); end
        tick();
        checks++; if (bus.InstPC !== 10'd1021 || bus.InstOut !== 9'h0FD) begin failures++; $display("FAIL br_wrap got=%0d/%h exp=1021/0fd", bus.InstPC, bus.InstOut); end
    endtask

    task automatic test_stall();
        do_start(10'd20);
        tick();
        tick();
        checks++; if (bus.InstPC !== 10'd21 || bus.CycleCount !== 16'd2) begin failures++; $display("FAIL st_pre got=%0d/%0d exp=21/2", bus.InstPC, bus.CycleCount); end
        bus.Stall = 1'b1;
        bus.BranchEn = 1'b1; bus.BranchRel = 1'b0; bus.BranchTarget = 10'd100;
        tick(); tick(); tick();
        checks++; if (bus.InstPC !== 10'd21 || bus.InstOut !== 9'h015 || bus.InstValid !== 1'b1 || bus.InstAddress !== 10'd22) begin failures++; $display("FAIL st_hold got=%0d/%h/%b/%0d exp=21/015/1/22", bus.InstPC, bus.InstOut, bus.InstValid, bus.InstAddress); end
        checks++; if (bus.CycleCount !== 16'd5) begin failures++; $display("FAIL st_count got=%0d exp=5", bus.CycleCount); end
        bus.Stall = 1'b0;
        bus.BranchEn = 1'b0;
        tick();
        checks++; if (bus.InstPC !== 10'd22 || bus.InstValid !== 1'b1 || bus.CycleCount !== 16'd6) begin failures++; $display("FAIL st_resume got=%0d/%b/%0d exp=22/1/6", bus.InstPC, bus.InstValid, bus.CycleCount); end
    endtask

    task automatic test_wrap_restart();
        do_start(10'd1023);
        tick();
        checks++; if (bus.InstPC !== 10'd1023 || bus.InstValid !== 1'b1) begin failures++; $display("FAIL wr_1023 got=%0d/%b exp=1023/1", bus.InstPC, bus.InstValid); end
        tick();
        checks++; if (bus.InstPC !== 10'd0 || bus.InstOut !== 9'h0A1) begin failures++; $display("FAIL wr_0 got=%0d/%h exp=0/0a1", bus.InstPC, bus.InstOut); end
        tick();
        checks++; if (bus.InstPC !== 10'd1 || bus.InstValid !== 1'b1) begin failures++; $display("FAIL wr_1 got=%0d/%b exp=1/1", bus.InstPC, bus.InstValid); end
        do_start(10'd50);
        checks++; if (bus.InstValid !== 1'b0 || bus.InstAddress !== 10'd50 || bus.CycleCount !== 16'd0) begin failures++; $display("FAIL rs_flush got=%b/%0d/%0d exp=0/50/0", bus.InstValid, bus.InstAddress, bus.CycleCount); end
        tick();
        checks++; if (bus.InstPC !== 10'd50 || bus.InstValid !== 1'b1) begin failures++; $display("FAIL rs_first got=%0d/%b exp=50/1", bus.InstPC, bus.InstValid); end
    endtask

    task automatic test_async_reset();
        rom[61] = HALT_WORD;
        do_start(10'd60);
        tick();
        checks++; if (bus.InstPC !== 10'd60 || bus.InstValid !== 1'b1) begin failures++; $display("FAIL ar_pre got=%0d/%b exp=60/1", bus.InstPC, bus.InstValid); end
        #3;
        Reset_n = 1'b0;
        #1;
        checks++; if (bus.InstValid !== 1'b0 || bus.InstPC !== 10'd0 || bus.InstOut !== 9'd0 || bus.InstAddress !== 10'd0 || bus.CycleCount !== 16'd0 || bus.Done !== 1'b0 || bus.Halted !== 1'b0) begin failures++; $display("FAIL ar_now got=%b/%0d/%h/%0d/%0d/%b%b exp=0/0/000/0/0/00", bus.InstValid, bus.InstPC, bus.InstOut, bus.InstAddress, bus.CycleCount, bus.Done, bus.Halted); end
        tick();
        Reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (bus.Done !== 1'b0 || bus.Halted !== 1'b0 || bus.InstValid !== 1'b0) begin failures++; $display("FAIL ar_nodone cyc=%0d got=%b%b%b exp=000", i, bus.Done, bus.Halted, bus.InstValid); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 1024; i++) rom[i] = {1'b0, 8'(i)};
        rom[0] = 9'h0A1;
        rom[1] = 9'h0A2;
        rom[2] = HALT_WORD;
        Reset_n = 1'b0;
        bus.Start = 1'b0;
        bus.StartAddr = '0;
        bus.Stall = 1'b0;
        bus.BranchEn = 1'b0;
        bus.BranchRel = 1'b0;
        bus.BranchOff = '0;
        bus.BranchTarget = '0;
        #12;
        test_reset();
        test_program_halt();
        test_branch_abs();
        test_branch_rel();
        test_stall();
        test_wrap_restart();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
